// File: rtl/clock_pkg.sv
// Shared types and limits for the clock-face timekeeper.
package clock_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

  // Increment with wrap to zero at max; fields narrower than 6 bits are zero-extended.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction
endpackage

// File: rtl/btn_pulse.sv
// Two-flop synchronizer followed by a registered rising-edge one-shot.
module btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      prev  <= sync[1];
      pulse <= sync[1] & ~prev;
    end
  end
endmodule

// File: rtl/clock_time_keeper.sv
// 1 Hz prescaler, 24-hour H:M:S counter and button-driven time-set FSM.
module clock_time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_MODE,
  input  logic             BTN_INC,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic [1:0]       set_mode,
  output logic             sec_tick
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);

  logic mode_p, inc_p;
  mode_t state, state_nx;
  logic [PW-1:0]    presc, presc_nx;
  logic [SEC_W-1:0] sec_nx;
  logic [MIN_W-1:0] min_nx;
  logic [HR_W-1:0]  hr_nx;
  logic             tick;

  btn_pulse u_mode (.clk(CLK), .rst(RST), .btn(BTN_MODE), .pulse(mode_p));
  btn_pulse u_inc  (.clk(CLK), .rst(RST), .btn(BTN_INC),  .pulse(inc_p));

  always_comb begin
    state_nx = state;
    sec_nx   = seconds;
    min_nx   = minutes;
    hr_nx    = hours;
    tick     = (state == RUN) && (presc == PS_LAST);

    // A mode press always wins; a simultaneous increment is discarded.
    unique case (state)
      RUN: begin
        if (mode_p) state_nx = SET_HR;
        if (tick) begin
          sec_nx = wrap_inc(seconds, SEC_MAX);
          if (seconds == SEC_MAX) begin
            min_nx = wrap_inc(minutes, MIN_MAX);
            if (minutes == MIN_MAX)
              hr_nx = HR_W'(wrap_inc({1'b0, hours}, {1'b0, HR_MAX}));
          end
        end
      end
      SET_HR: begin
        if (mode_p)     state_nx = SET_MIN;
        else if (inc_p) hr_nx = HR_W'(wrap_inc({1'b0, hours}, {1'b0, HR_MAX}));
      end
      SET_MIN: begin
        if (mode_p)     state_nx = SET_SEC;
        else if (inc_p) min_nx = wrap_inc(minutes, MIN_MAX);
      end
      SET_SEC: begin
        if (mode_p)     state_nx = RUN;
        else if (inc_p) sec_nx = wrap_inc(seconds, SEC_MAX);
      end
      default: state_nx = RUN;
    endcase

    // Prescaler parks at 0 whenever the next state is a set state or on return to RUN.
    if (state_nx != RUN || state != RUN) presc_nx = '0;
    else if (tick)                      presc_nx = '0;
    else                                presc_nx = presc + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      presc    <= '0;
      seconds  <= '0;
      minutes  <= '0;
      hours    <= '0;
      sec_tick <= 1'b0;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      seconds  <= sec_nx;
      minutes  <= min_nx;
      hours    <= hr_nx;
      sec_tick <= tick;
    end
  end

  assign set_mode = state;
endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed scoreboard bench for clock_time_keeper with a 4-cycle second.
module tb_clock_time_keeper;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_MODE = 1'b0;
  logic       BTN_INC = 1'b0;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic [1:0] set_mode;
  logic       sec_tick;

  clock_time_keeper #(.CLK_HZ(4)) dut (
    .CLK(CLK), .RST(RST), .BTN_MODE(BTN_MODE), .BTN_INC(BTN_INC),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .set_mode(set_mode), .sec_tick(sec_tick)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
    logic       tk;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int eh = 0, em = 0, es = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pop_check();
    exp_t e;
    logic [19:0] obs, want;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: no expected entry");
      return;
    end
    e = sb.pop_front();
    vectors++;
    obs  = {hours, minutes, seconds, set_mode, sec_tick};
    want = {e.h, e.m, e.s, e.md, e.tk};
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d:%0d:%0d mode=%0d tick=%0b, expected %0d:%0d:%0d mode=%0d tick=%0b",
             e.tag, hours, minutes, seconds, set_mode, sec_tick, e.h, e.m, e.s, e.md, e.tk);
    end
  endtask

  // Record the expected outputs from the model, advance n cycles, then compare.
  task automatic expect_after(input int n, input string tag, input int md, input int tk);
    exp_t e;
    e.tag = tag;
    e.h = 5'(eh); e.m = 6'(em); e.s = 6'(es);
    e.md = 2'(md); e.tk = 1'(tk);
    sb.push_back(e);
    cyc(n);
    pop_check();
  endtask

  // Full press: high long enough to pulse, low long enough to re-arm the edge detector.
  task automatic press(input bit inc);
    if (inc) BTN_INC = 1'b1; else BTN_MODE = 1'b1;
    cyc(4);
    BTN_INC = 1'b0;
    BTN_MODE = 1'b0;
    cyc(4);
  endtask

  task automatic inc_hr(input int n);
    for (int i = 0; i < n; i++) begin press(1'b1); eh = (eh + 1) % 24; end
  endtask
  task automatic inc_min(input int n);
    for (int i = 0; i < n; i++) begin press(1'b1); em = (em + 1) % 60; end
  endtask
  task automatic inc_sec(input int n);
    for (int i = 0; i < n; i++) begin press(1'b1); es = (es + 1) % 60; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and first tick
    RST = 1'b1;
    cyc(3);
    expect_after(0, "reset", 0, 0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) expect_after(1, "pre_tick", 0, 0);
    es = 1; expect_after(1, "first_tick", 0, 1);
    expect_after(1, "tick_low", 0, 0);
    expect_after(2, "between_ticks", 0, 0);
    es = 2; expect_after(1, "second_tick", 0, 1);

    // Set mode entry: the mode edge lands on the same edge as a tick
    RST = 1'b1; cyc(3); RST = 1'b0;
    eh = 0; em = 0; es = 0;
    BTN_MODE = 1'b1;
    es = 1; expect_after(4, "enter_set_hr", 1, 1);
    BTN_MODE = 1'b0;
    for (int i = 0; i < 4; i++) expect_after(10, "frozen", 1, 0);
    inc_hr(25);
    expect_after(0, "hr_inc25", 1, 0);
    BTN_INC = 1'b1;
    eh = 2; expect_after(5, "hold_inc_first", 1, 0);
    cyc(15);
    BTN_INC = 1'b0;
    expect_after(4, "hold_inc_once", 1, 0);

    // Day rollover from 23:59:59
    inc_hr(21);
    press(1'b0);
    expect_after(0, "mode_set_min", 2, 0);
    inc_min(59);
    press(1'b0);
    inc_sec(58);
    expect_after(0, "at_235959", 3, 0);
    BTN_MODE = 1'b1;
    expect_after(4, "back_to_run", 0, 0);
    BTN_MODE = 1'b0;
    expect_after(3, "run_wait", 0, 0);
    eh = 0; em = 0; es = 0;
    expect_after(1, "day_rollover", 0, 1);

    // Minute carry from 00:00:59
    BTN_MODE = 1'b1;
    es = 1; expect_after(4, "enter_hr2", 1, 1);
    BTN_MODE = 1'b0; cyc(4);
    press(1'b0); press(1'b0);
    inc_sec(58);
    BTN_MODE = 1'b1;
    expect_after(4, "run2", 0, 0);
    BTN_MODE = 1'b0; cyc(3);
    em = 1; es = 0;
    expect_after(1, "minute_carry", 0, 1);

    // Hour carry from 00:59:59
    BTN_MODE = 1'b1;
    es = 1; expect_after(4, "enter_hr3", 1, 1);
    BTN_MODE = 1'b0; cyc(4);
    press(1'b0);
    inc_min(58);
    press(1'b0);
    inc_sec(58);
    BTN_MODE = 1'b1;
    expect_after(4, "run3", 0, 0);
    BTN_MODE = 1'b0; cyc(3);
    eh = 1; em = 0; es = 0;
    expect_after(1, "hour_carry", 0, 1);

    // Simultaneous mode and increment in SET_MIN
    BTN_MODE = 1'b1;
    es = 1; expect_after(4, "enter_hr4", 1, 1);
    BTN_MODE = 1'b0; cyc(4);
    press(1'b0);
    inc_min(7);
    expect_after(0, "min_is_7", 2, 0);
    BTN_MODE = 1'b1; BTN_INC = 1'b1;
    expect_after(4, "simultaneous", 3, 0);
    BTN_MODE = 1'b0; BTN_INC = 1'b0;
    expect_after(4, "simultaneous_settle", 3, 0);

    // Build 12:34:56 in SET_MIN, then reset mid-set
    inc_sec(53);
    BTN_MODE = 1'b1;
    expect_after(4, "run5", 0, 0);
    BTN_MODE = 1'b0;
    es = 55; expect_after(4, "restart_tick", 0, 1);
    BTN_MODE = 1'b1;
    es = 56; expect_after(4, "enter_hr5", 1, 1);
    BTN_MODE = 1'b0; cyc(4);
    inc_hr(11);
    press(1'b0);
    inc_min(27);
    expect_after(0, "at_123456", 2, 0);
    RST = 1'b1;
    eh = 0; em = 0; es = 0;
    expect_after(1, "reset_mid_set", 0, 0);
    RST = 1'b0;
    expect_after(3, "post_reset_wait", 0, 0);
    es = 1; expect_after(1, "post_reset_tick", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

Timekeeping stage that feeds the VGA clock-face renderer. It divides the board clock down to a 1 Hz tick and keeps a 24-hour hours/minutes/seconds count. The count drives the renderer's `seconds`, `minutes` and `hours` inputs directly. Two push buttons set the time through a small mode state machine; while a field is being set, counting is frozen.

## Interface
Parameters:
- CLK_HZ, 100_000_000, CLK cycles per second tick; the bench overrides it with a small value (e.g. 4).

Ports:
- CLK  in  1  board clock; the single clock domain for the whole block.
- RST  in  1  synchronous, active-high reset.
- BTN_MODE  in  1  raw push button, asynchronous level; each rising edge advances the set mode.
- BTN_INC  in  1  raw push button, asynchronous level; each rising edge increments the selected field.
- seconds  out  6  0..59, registered.
- minutes  out  6  0..59, registered.
- hours  out  5  0..23, registered.
- set_mode  out  2  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC; registered.
- sec_tick  out  1  one-cycle pulse in the cycle a run-mode seconds increment first appears.

## Operation
Button conditioning:
- Each button passes through a 2-FF synchronizer, then a rising-edge detector.
- Each rising edge produces a single one-cycle pulse (mode_p, inc_p).
- Holding a button high produces exactly one pulse.

Prescaler:
- Counter runs 0..CLK_HZ-1 and wraps to 0.
- Internal tick is true when the counter equals CLK_HZ-1 and the state is RUN.
- Width is $clog2(CLK_HZ).

RUN state, on each tick:
- seconds increments; at 59 it wraps to 0 and carries into minutes.
- minutes at 59 wraps to 0 and carries into hours.
- hours at 23 wraps to 0.
- Values 60 and 24 are never emitted, although the downstream decoder tolerates them.

FSM (mode_p advances the state):
- RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
- In any SET_* state, the prescaler is held at 0 and no tick occurs.
- In a SET_* state, inc_p increments only the selected field, with its own wrap (23->0 or 59->0) and no carry.
- On SET_SEC -> RUN, the prescaler restarts from 0.

Simultaneous events:
- mode_p and inc_p in the same cycle: the state advances, and the increment is dropped.
- A tick never coincides with a SET_* state.

Reset:
- RST at any time, including mid-set, forces seconds=minutes=hours=0, set_mode=0 (RUN), sec_tick=0 and prescaler=0.
- Synchronizer and edge-detector flops are cleared to 0. A button already held high through reset therefore yields a pulse once it is synchronized.

## Timing
- Reset values: all outputs 0.
- Button pin rising edge to field/state update visible on the outputs: 4 CLK edges (2 sync + 1 edge register + 1 output register).
- After the first cycle with RST low, seconds becomes 1 and sec_tick pulses exactly CLK_HZ cycles later; subsequent increments follow every CLK_HZ cycles.
- The tick cycle is the one with prescaler == CLK_HZ-1. seconds, minutes, hours and sec_tick all update on the same edge, so a carry never shows intermediate values.
- Leaving SET_SEC: the first increment appears CLK_HZ cycles after set_mode reads 0.
- set_mode changes on the edge following mode_p.

## Structure
- Package clock_pkg holds:
  - mode typedef (RUN, SET_HR, SET_MIN, SET_SEC, 2 bits);
  - constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23;
  - widths SEC_W=6, MIN_W=6, HR_W=5.
- One sub-module, btn_pulse (synchronizer plus rising-edge pulse), instantiated for BTN_MODE and BTN_INC.
- Prescaler, counters and FSM live in clock_time_keeper.

## Test plan
All scenarios use CLK_HZ=4.
- Reset/first tick: hold RST for 3 cycles, then release -> outputs all 0 and set_mode=0; seconds=1 and sec_tick=1 exactly 4 cycles after release, sec_tick low otherwise.
- Day rollover: set 23:59:59 and return to RUN -> after 4 cycles the outputs read 00:00:00 in a single edge, sec_tick=1.
- Minute carry: from 00:00:59 -> next tick 00:01:00; from 00:59:59 -> 01:00:00.
- Set mode: one BTN_MODE pulse -> set_mode=1 and counters frozen for 40 cycles. Then 25 BTN_INC edges -> hours=1, minutes and seconds unchanged. A BTN_INC held high for 20 cycles -> exactly 1 increment.
- Simultaneous press: BTN_MODE and BTN_INC rise in the same cycle while in SET_MIN with minutes=7 -> set_mode=3, minutes stays 7.
- Reset mid-set: at 12:34:56 in SET_MIN, assert RST for 1 cycle -> the next cycle shows 00:00:00 with set_mode=0, and the first increment lands 4 cycles after RST deasserts.
